aes_iter_cipher: RTL and testbench
==================================

Name: aes_iter_cipher

Overview:
Iterative AES round engine covering both encryption and decryption, selected per transaction, for 128, 192 and 256-bit keys. It fetches one round key per round from an external key store through an address/valid interface that may stall. Input and output use valid/ready handshakes, so the engine sits between the DMA front-end and the result buffer. It adds output backpressure, abort, error reporting and a configurable key address width.

Parameters:
KEY_ADDR_W, 4, width of subkey_addr; must be >= 4 so that round index 14 fits.
SUPPORT_ENC, 1, 1 = encrypt mode implemented; 0 = encrypt requests complete with err.
SUPPORT_DEC, 1, 1 = decrypt mode implemented; 0 = decrypt requests complete with err.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  engine can accept a request
in_data  in  128  plaintext (enc) or ciphertext (dec)
in_mode  in  1  0 = encrypt, 1 = decrypt
key_len  in  2  01 = AES-128, 10 = AES-192, 11 = AES-256, 00 = invalid
subkey_addr  out  KEY_ADDR_W  round-key index requested
subkey  in  128  round key for subkey_addr
subkey_valid  in  1  subkey valid this cycle for the current subkey_addr
abort  in  1  cancel the in-flight transaction
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_data  out  128  result
out_err  out  1  result is an error response; out_data = 0

Behaviour:
- Clock and reset: clk, rising edge. reset is synchronous and active-high. It applies in any state, including mid-operation.
- Reset values: state = IDLE, out_valid = 0, out_err = 0, out_data = 0, subkey_addr = 0, internal state register = 0. in_ready is 1 in the cycle after reset deasserts.
- Byte order: byte i sits at bits [127-8i:120-8i]. Byte i is row i%4, column i/4 (FIPS-197 column-major order).
- Nr is 10, 12 or 14 for key_len 01, 10 or 11. Nr, mode and data are latched at acceptance; later changes to the inputs are ignored.
- in_ready = (state == IDLE). Acceptance happens on in_valid & in_ready.

State machine:
- IDLE: on acceptance, latch the request.
  - If key_len == 00, or the mode is unsupported: go to DONE with out_err = 1 and out_data = 0. No subkey fetch occurs.
  - Otherwise set subkey_addr to 0 (enc) or Nr (dec), round counter = 1, go to INIT.
- INIT: wait for subkey_valid. When it is high, state = in_data ^ subkey and subkey_addr steps by +1 (enc) or -1 (dec). Go to ROUND.
- ROUND: wait for subkey_valid. When it is high, apply one round and increment the round counter.
  - Encrypt round: SubBytes, ShiftRows, MixColumns (omitted when the counter == Nr), AddRoundKey.
  - Decrypt round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (omitted when the counter == Nr).
  - If the counter == Nr: load out_data with the round result, set out_valid = 1, go to DONE. Otherwise step subkey_addr.
- DONE: hold out_valid, out_data and out_err stable until out_ready. On out_valid & out_ready, clear out_valid and out_err and go to IDLE. out_data keeps its last value.

Timing and handshakes:
- subkey_addr only changes on a key-consuming edge. While subkey_valid = 0, the engine holds the address and the state: a wait state.
- Latency with subkey_valid held high: out_valid rises Nr+1 cycles after the acceptance edge (11, 13 or 15 cycles).
- Throughput: the minimum spacing between acceptances is Nr+3 cycles when out_ready is held high.

Boundary conditions:
- abort in INIT or ROUND: go to IDLE next cycle and discard the state; out_valid stays 0. abort has priority over subkey_valid in the same cycle. abort in IDLE or DONE is ignored, so a result is never dropped.
- The decrypt address never underflows: the last key used is index 0. The encrypt address ends at Nr.
- A new in_valid during INIT, ROUND or DONE is not accepted, because in_ready = 0.

Test Plan:
- AES-128 encrypt: key 000102…0f, in_data 00112233445566778899aabbccddeeff, subkey_valid = 1 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 11 cycles after acceptance, addresses 0..10 in order.
- AES-192 and AES-256 decrypt using the FIPS-197 C.2/C.3 keys: ciphertexts dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089 -> plaintext 00112233…eeff in both cases; addresses descend 12..0 and 14..0.
- AES-128 encrypt with a random 0–3 cycle subkey_valid gap per key, and out_ready held low for 5 cycles -> same ciphertext, subkey_addr stable during every gap, out_data stable while out_valid = 1 and out_ready = 0.
- key_len = 00 request -> out_valid 1 cycle after acceptance, out_err = 1, out_data = 0, subkey_addr unchanged. With SUPPORT_DEC = 0 and a decrypt request -> the same error response.
- abort asserted at round 5 together with subkey_valid -> IDLE next cycle, no out_valid, and in_ready = 1. A following AES-128 request produces the correct ciphertext.
- reset asserted mid-ROUND -> all outputs at their reset values next cycle. A new request after reset completes correctly.

Source files
------------

// File: rtl/aes_iter_cipher.sv
// aes_iter_cipher: iterative AES-128/192/256 encrypt/decrypt engine, one round
// per accepted round key. Round keys come from an external store addressed by
// subkey_addr; the engine waits while subkey_valid is low.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     request handshake; in_data, in_mode (0 enc, 1 dec),
//                         key_len (01/10/11 = 128/192/256, 00 invalid)
//   subkey_addr/subkey/   round-key fetch; subkey is valid for subkey_addr
//   subkey_valid          when subkey_valid is high
//   abort                 cancels a transaction in INIT or ROUND
//   out_valid/out_ready   result handshake; out_data, out_err (error => data 0)
module aes_iter_cipher #(
    parameter int KEY_ADDR_W  = 4,
    parameter bit SUPPORT_ENC = 1'b1,
    parameter bit SUPPORT_DEC = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in_data,
    input  logic                  in_mode,
    input  logic [1:0]            key_len,
    output logic [KEY_ADDR_W-1:0] subkey_addr,
    input  logic [127:0]          subkey,
    input  logic                  subkey_valid,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic                  out_err
);

    typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} state_t;

    state_t                  state_q, state_d;
    logic [127:0]            blk_q, blk_d;
    logic [KEY_ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]              rnd_q, rnd_d;
    logic [3:0]              nr_q, nr_d;
    logic                    mode_q, mode_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_err_q, out_err_d;
    logic [127:0]            out_data_q, out_data_d;

    logic [127:0]            rnd_res;
    logic                    rnd_last;
    logic [3:0]              nr_sel;
    logic                    unsupported;
    logic [KEY_ADDR_W-1:0]   addr_step;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] a);
        return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    // Byte i is row i%4, column i/4; ShiftRows reads row r from column c+r.
    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        logic [127:0] m;
        logic [7:0]   a0, a1, a2, a3;
        int           src;
        for (int i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
            t[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
        end
        m = t;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[127-32*c -: 8];
                a1 = t[119-32*c -: 8];
                a2 = t[111-32*c -: 8];
                a3 = t[103-32*c -: 8];
                m[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                m[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                m[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                m[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        return m ^ k;
    endfunction

    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        logic [127:0] m;
        logic [7:0]   a0, a1, a2, a3;
        int           src;
        for (int i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
            t[127-8*i -: 8] = isbox(s[127-8*src -: 8]);
        end
        t = t ^ k;
        m = t;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[127-32*c -: 8];
                a1 = t[119-32*c -: 8];
                a2 = t[111-32*c -: 8];
                a3 = t[103-32*c -: 8];
                m[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                m[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                m[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                m[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
        end
        return m;
    endfunction

    always_comb begin
        rnd_last  = (rnd_q == nr_q);
        rnd_res   = mode_q ? dec_round(blk_q, subkey, rnd_last)
                           : enc_round(blk_q, subkey, rnd_last);
        addr_step = mode_q ? addr_q - KEY_ADDR_W'(1) : addr_q + KEY_ADDR_W'(1);
        nr_sel    = (key_len == 2'b01) ? 4'd10 : (key_len == 2'b10) ? 4'd12 : 4'd14;
        unsupported = in_mode ? !SUPPORT_DEC : !SUPPORT_ENC;
    end

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        addr_d      = addr_q;
        rnd_d       = rnd_q;
        nr_d        = nr_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d = in_mode;
                    nr_d   = nr_sel;
                    if (key_len == 2'b00 || unsupported) begin
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_data_d  = '0;
                        state_d     = DONE;
                    end else begin
                        blk_d   = in_data;
                        addr_d  = in_mode ? KEY_ADDR_W'(nr_sel) : '0;
                        rnd_d   = 4'd1;
                        state_d = INIT;
                    end
                end
            end
            INIT: begin
                if (abort) begin
                    blk_d   = '0;
                    state_d = IDLE;
                end else if (subkey_valid) begin
                    blk_d   = blk_q ^ subkey;
                    addr_d  = addr_step;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (abort) begin
                    blk_d   = '0;
                    state_d = IDLE;
                end else if (subkey_valid) begin
                    blk_d = rnd_res;
                    rnd_d = rnd_q + 4'd1;
                    if (rnd_last) begin
                        out_data_d  = rnd_res;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        addr_d = addr_step;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            blk_q       <= '0;
            addr_q      <= '0;
            rnd_q       <= '0;
            nr_q        <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            addr_q      <= addr_d;
            rnd_q       <= rnd_d;
            nr_q        <= nr_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign subkey_addr = addr_q;
    assign out_valid   = out_valid_q;
    assign out_err     = out_err_q;
    assign out_data    = out_data_q;

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Self-checking bench for aes_iter_cipher: FIPS-197 vectors, a key-store model
// with optional stalls, a scoreboard/monitor pair, abort, reset and error cases.
module tb_aes_iter_cipher;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         in_mode = 1'b0;
    logic [1:0]   key_len = 2'b01;
    logic [3:0]   subkey_addr;
    logic [127:0] subkey;
    logic         subkey_valid = 1'b1;
    logic         abort = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         out_err;

    logic         in_valid2 = 1'b0;
    logic         in_ready2;
    logic [3:0]   subkey_addr2;
    logic         out_valid2;
    logic [127:0] out_data2;
    logic         out_err2;

    always #5 clk = ~clk;

    aes_iter_cipher #(.KEY_ADDR_W(4), .SUPPORT_ENC(1'b1), .SUPPORT_DEC(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .key_len(key_len),
        .subkey_addr(subkey_addr), .subkey(subkey), .subkey_valid(subkey_valid),
        .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err));

    aes_iter_cipher #(.KEY_ADDR_W(4), .SUPPORT_ENC(1'b1), .SUPPORT_DEC(1'b0)) u_nodec (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data), .in_mode(in_mode), .key_len(key_len),
        .subkey_addr(subkey_addr2), .subkey(subkey), .subkey_valid(subkey_valid),
        .abort(1'b0), .out_valid(out_valid2), .out_ready(1'b1),
        .out_data(out_data2), .out_err(out_err2));

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic [2047:0] sbox_t = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic [127:0] rk [0:15];
    assign subkey = rk[subkey_addr];

    typedef struct packed { logic err; logic [127:0] data; } exp_t;
    exp_t       sb_q [$];
    logic [3:0] addr_log [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       busy    = 1'b0;
    logic       gap_en  = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[31-8*i -: 8] = sbox_t[2047 - 8*int'(w[31-8*i -: 8]) -: 8];
        return r;
    endfunction

    task automatic load_keys(input logic [255:0] key, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Key store stall generator: a random 0..3 cycle gap after each valid beat.
    initial begin
        int gap_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!gap_en) begin
                subkey_valid = 1'b1;
                gap_cnt = 0;
            end else if (gap_cnt > 0) begin
                subkey_valid = 1'b0;
                gap_cnt--;
            end else if (!subkey_valid) begin
                subkey_valid = 1'b1;
            end else begin
                gap_cnt = $urandom_range(0, 3);
                if (gap_cnt > 0) begin
                    subkey_valid = 1'b0;
                    gap_cnt--;
                end
            end
        end
    end

    // Output monitor: pop on each handshake, check stability while stalled.
    initial begin
        logic         hold_prev = 1'b0;
        logic [127:0] hold_data = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_prev = 1'b0;
            end else begin
                if (out_valid && hold_prev) check("out_data_hold", out_data, hold_data);
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("out_valid_unexpected", out_valid, 1'b0);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_err", out_err, e.err);
                        check("out_data", out_data, e.data);
                    end
                end
                hold_prev = out_valid && !out_ready;
                hold_data = out_data;
            end
        end
    end

    // Key-address monitor: log consumed addresses, check the address holds in wait states.
    initial begin
        logic       gap_prev = 1'b0;
        logic [3:0] gap_addr = '0;
        forever begin
            @(negedge clk);
            if (busy && !out_valid && !reset) begin
                if (subkey_valid) addr_log.push_back(subkey_addr);
                else if (gap_prev) check("subkey_addr_hold", subkey_addr, gap_addr);
                gap_prev = !subkey_valid;
                gap_addr = subkey_addr;
            end else begin
                gap_prev = 1'b0;
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic m, input logic [1:0] len,
                        input logic push, input logic err, input logic [127:0] expd);
        int n = 0;
        while (!in_ready && n < 100) begin step(); n++; end
        if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
        addr_log.delete();
        in_valid = 1'b1; in_data = d; in_mode = m; key_len = len;
        step();
        in_valid = 1'b0; in_data = ~d; in_mode = ~m; key_len = 2'b00;
        if (push) sb_q.push_back('{err, expd});
        busy = !err;
    endtask

    // exp_lat < 0 skips the latency check; nr == 0 skips the address-order check.
    task automatic finish_req(input int nr, input logic m, input int exp_lat, input int hold);
        int n = 0;
        while (!out_valid && n < 300) begin step(); n++; end
        if (!out_valid) check("out_valid_timeout", out_valid, 1'b1);
        else if (exp_lat >= 0) check("latency", n, exp_lat);
        busy = 1'b0;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) step();
            out_ready = 1'b1;
        end
        n = 0;
        while (out_valid && n < 20) begin step(); n++; end
        if (out_valid) check("out_valid_clear_timeout", out_valid, 1'b0);
        if (nr > 0) begin
            check("addr_count", addr_log.size(), nr + 1);
            for (int i = 0; i < addr_log.size() && i <= nr; i++)
                check("addr_seq", addr_log[i], m ? nr - i : i);
        end
    endtask

    initial begin
        logic [3:0] addr_before;
        int         n;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        step(); step(); step();
        reset = 1'b0;
        step();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_out_data", out_data, 128'h0);
        check("rst_subkey_addr", subkey_addr, 4'h0);

        load_keys(KEY128, 4);
        send(PT, 1'b0, 2'b01, 1'b1, 1'b0, CT128);
        finish_req(10, 1'b0, 11, 0);

        load_keys(KEY192, 6);
        send(CT192, 1'b1, 2'b10, 1'b1, 1'b0, PT);
        finish_req(12, 1'b1, 13, 0);

        load_keys(KEY256, 8);
        send(CT256, 1'b1, 2'b11, 1'b1, 1'b0, PT);
        finish_req(14, 1'b1, 15, 0);

        load_keys(KEY192, 6);
        send(PT, 1'b0, 2'b10, 1'b1, 1'b0, CT192);
        finish_req(12, 1'b0, 13, 0);

        load_keys(KEY128, 4);
        send(CT128, 1'b1, 2'b01, 1'b1, 1'b0, PT);
        finish_req(10, 1'b1, 11, 0);

        // Stalling key store plus result backpressure.
        gap_en = 1'b1;
        out_ready = 1'b0;
        send(PT, 1'b0, 2'b01, 1'b1, 1'b0, CT128);
        finish_req(10, 1'b0, -1, 5);
        gap_en = 1'b0;
        step();

        // Invalid key length: error visible right after the accepting edge.
        addr_before = subkey_addr;
        send(PT, 1'b0, 2'b00, 1'b1, 1'b1, 128'h0);
        finish_req(0, 1'b0, 0, 0);
        check("err_addr_unchanged", subkey_addr, addr_before);

        // Abort while round 5 is being consumed.
        send(PT, 1'b0, 2'b01, 1'b0, 1'b0, 128'h0);
        n = 0;
        while (subkey_addr != 4'd5 && n < 50) begin step(); n++; end
        check("abort_reach_round5", subkey_addr, 4'd5);
        abort = 1'b1;
        busy = 1'b0;
        step();
        abort = 1'b0;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 15; i++) step();
        send(PT, 1'b0, 2'b01, 1'b1, 1'b0, CT128);
        finish_req(10, 1'b0, 11, 0);

        // Reset in the middle of ROUND.
        load_keys(KEY256, 8);
        send(PT, 1'b0, 2'b11, 1'b0, 1'b0, 128'h0);
        n = 0;
        while (subkey_addr != 4'd3 && n < 50) begin step(); n++; end
        check("reset_reach_round3", subkey_addr, 4'd3);
        reset = 1'b1;
        busy = 1'b0;
        step();
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_err", out_err, 1'b0);
        check("midrst_out_data", out_data, 128'h0);
        check("midrst_subkey_addr", subkey_addr, 4'h0);
        reset = 1'b0;
        step();
        check("midrst_in_ready", in_ready, 1'b1);
        send(PT, 1'b0, 2'b11, 1'b1, 1'b0, CT256);
        finish_req(14, 1'b0, 15, 0);

        // Decrypt on an encrypt-only engine completes with an error.
        in_valid2 = 1'b1; in_mode = 1'b1; key_len = 2'b01; in_data = CT128;
        step();
        in_valid2 = 1'b0;
        check("nodec_out_valid", out_valid2, 1'b1);
        check("nodec_out_err", out_err2, 1'b1);
        check("nodec_out_data", out_data2, 128'h0);
        check("nodec_subkey_addr", subkey_addr2, 4'h0);
        step();
        check("nodec_out_valid_clear", out_valid2, 1'b0);
        check("nodec_in_ready", in_ready2, 1'b1);

        step(); step();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
